// File: rtl/rr_arbiter_16_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
package rr_arbiter_16_pkg;

  localparam int N_REQ  = 16;
  localparam int IDX_W  = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot      = '0;
    idx_to_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_16_pick.sv
// Combinational round-robin picker: first set bit of req & ~excl searching
// upward from last_idx+1 and wrapping, so last_idx itself is examined last.
module rr_pick16
  import rr_arbiter_16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  input  logic [N_REQ-1:0] excl,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_valid
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] offset;

  assign masked = req & ~excl;
  assign start  = last_idx + IDX_W'(1);

  // Rotate so bit 0 of rot corresponds to requester start.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = masked[start + IDX_W'(i)];
    end
  end

  always_comb begin
    offset     = '0;
    pick_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset     = IDX_W'(i);
        pick_valid = 1'b1;
      end
    end
  end

  assign pick_idx = start + offset;

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with registered one-hot grant and hold-until-release.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] excl;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             release_w;
  logic             hold_expire;
`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
`endif

  rr_pick16 u_pick (
    .req        (req),
    .last_idx   (last_idx_q),
    .excl       (excl),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_idx_d  = last_idx_q;
    excl        = '0;
    release_w   = 1'b0;
    hold_expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
    // done on the expiry cycle wins, so no timeout is reported then.
    hold_expire = (hold_q == HOLD_W'(MAX_HOLD)) && !done;
`endif
    case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          state_d    = GRANT;
          gnt_idx_d  = pick_idx;
          last_idx_d = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d     = HOLD_W'(1);
`endif
        end
      end
      GRANT: begin
        // Excluding the owner lets a competing requester take over directly.
        excl      = idx_to_onehot(gnt_idx_q);
        release_w = done || !req[gnt_idx_q] || hold_expire;
        if (release_w) begin
`ifdef ARB_TIMEOUT_EN
          timeout_d = hold_expire;
          hold_d    = HOLD_W'(1);
`endif
          if (en && pick_valid) begin
            gnt_idx_d  = pick_idx;
            last_idx_d = pick_idx;
          end else if (!(en && req[gnt_idx_q])) begin
            state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? idx_to_onehot(gnt_idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= '1;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      gnt_q      <= gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == GRANT);

endmodule
